// File: rtl/crc_serial_framer.sv
// Bit-serial CRC engine with valid/ready streams: GEN appends the CRC after the message,
// CHECK compares the trailing WIDTH bits of the frame against the CRC of the bits before them.
module crc_serial_framer #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] POLY        = WIDTH'(8'h07),
  parameter logic [WIDTH-1:0] INIT        = '0,
  parameter logic [WIDTH-1:0] XOR_OUT     = '0,
  parameter bit               REFLECT_OUT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_data,
  output logic             out_last,
  output logic [WIDTH-1:0] crc,
  output logic             crc_valid,
  output logic             crc_ok,
  output logic             short_err
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH + 1);
  localparam logic [CW-1:0] APP_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    APPEND = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic             mode_reg, mode_next;
  logic [WIDTH-1:0] r_reg, r_next;
  logic [WIDTH-1:0] win_reg, win_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] sh_reg, sh_next;
  logic [CW-1:0]    app_cnt_reg, app_cnt_next;
  logic [WIDTH-1:0] crc_reg, crc_next;
  logic             crc_valid_reg, crc_valid_next;
  logic             crc_ok_reg, crc_ok_next;
  logic             short_err_reg, short_err_next;

  logic             mode_eff;
  logic [WIDTH-1:0] r_base, win_base, r_upd, win_upd;
  logic [CW-1:0]    cnt_base, cnt_upd;
  logic             lfsr_bit;
  logic [WIDTH-1:0] fin_xor, fin_rev, fin;
  logic             in_xfer, out_xfer;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] r, input logic b);
    logic fb;
    fb = r[WIDTH-1] ^ b;
    return {r[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
  endfunction

  // A frame's first bit sees fresh INIT/empty window state regardless of leftovers.
  always_comb begin
    mode_eff = (state_reg == IDLE) ? mode    : mode_reg;
    r_base   = (state_reg == IDLE) ? INIT    : r_reg;
    win_base = (state_reg == IDLE) ? '0      : win_reg;
    cnt_base = (state_reg == IDLE) ? '0      : cnt_reg;
    lfsr_bit = mode_eff ? win_base[WIDTH-1] : in_data;
    // CHECK only feeds the LFSR with bits leaving a full window, so the CRC field is excluded.
    r_upd    = (!mode_eff || (cnt_base >= CNT_FULL)) ? lfsr_step(r_base, lfsr_bit) : r_base;
    win_upd  = {win_base[WIDTH-2:0], in_data};
    cnt_upd  = (cnt_base == CNT_SAT) ? cnt_base : cnt_base + 1'b1;
  end

  assign fin_xor = r_upd ^ XOR_OUT;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_rev
      assign fin_rev[gi] = fin_xor[WIDTH-1-gi];
    end
  endgenerate

  assign fin = REFLECT_OUT ? fin_rev : fin_xor;

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = 1'b0;
    out_last  = 1'b0;
    case (state_reg)
      IDLE, DATA: begin
        out_valid = in_valid;
        out_data  = in_data;
        in_ready  = out_ready;
        out_last  = mode_eff & in_last;
      end
      APPEND: begin
        out_valid = 1'b1;
        out_data  = sh_reg[WIDTH-1];
        out_last  = (app_cnt_reg == APP_LAST);
      end
      default: ;
    endcase
  end

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_comb begin
    state_next     = state_reg;
    mode_next      = mode_reg;
    r_next         = r_reg;
    win_next       = win_reg;
    cnt_next       = cnt_reg;
    sh_next        = sh_reg;
    app_cnt_next   = app_cnt_reg;
    crc_next       = crc_reg;
    crc_valid_next = crc_valid_reg;
    crc_ok_next    = crc_ok_reg;
    short_err_next = short_err_reg;
    case (state_reg)
      IDLE, DATA: begin
        if (in_xfer) begin
          mode_next  = mode_eff;
          r_next     = r_upd;
          win_next   = win_upd;
          cnt_next   = cnt_upd;
          state_next = DATA;
          if (state_reg == IDLE) begin
            crc_valid_next = 1'b0;
            crc_ok_next    = 1'b0;
            short_err_next = 1'b0;
          end
          if (in_last) begin
            if (mode_eff) begin
              crc_next       = fin;
              crc_valid_next = 1'b1;
              crc_ok_next    = (win_upd == fin) && (cnt_upd > CNT_FULL);
              short_err_next = (cnt_upd <= CNT_FULL);
              state_next     = IDLE;
            end else begin
              sh_next      = fin;
              app_cnt_next = '0;
              state_next   = APPEND;
            end
          end
        end
      end
      APPEND: begin
        if (out_xfer) begin
          // Rotate rather than shift: after WIDTH steps sh_reg holds fin again.
          sh_next      = {sh_reg[WIDTH-2:0], sh_reg[WIDTH-1]};
          app_cnt_next = app_cnt_reg + 1'b1;
          if (app_cnt_reg == APP_LAST) begin
            crc_next       = sh_next;
            crc_valid_next = 1'b1;
            state_next     = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      mode_reg      <= 1'b0;
      r_reg         <= INIT;
      win_reg       <= '0;
      cnt_reg       <= '0;
      sh_reg        <= '0;
      app_cnt_reg   <= '0;
      crc_reg       <= '0;
      crc_valid_reg <= 1'b0;
      crc_ok_reg    <= 1'b0;
      short_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mode_reg      <= mode_next;
      r_reg         <= r_next;
      win_reg       <= win_next;
      cnt_reg       <= cnt_next;
      sh_reg        <= sh_next;
      app_cnt_reg   <= app_cnt_next;
      crc_reg       <= crc_next;
      crc_valid_reg <= crc_valid_next;
      crc_ok_reg    <= crc_ok_next;
      short_err_reg <= short_err_next;
    end
  end

  assign crc       = crc_reg;
  assign crc_valid = crc_valid_reg;
  assign crc_ok    = crc_ok_reg;
  assign short_err = short_err_reg;

endmodule

// File: tb/tb_crc_serial_framer.sv
// Directed bench for crc_serial_framer: CRC-8/0x07 instance and CRC-16/0x1021 (INIT FFFF) instance.
module tb_crc_serial_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, mode, in_valid, in_data, in_last, out_ready, sel16;

  logic        ir8, ov8, od8, ol8, cv8, ok8, se8;
  logic [7:0]  crc8;
  logic        ir16, ov16, od16, ol16, cv16, ok16, se16;
  logic [15:0] crc16;

  crc_serial_framer #(.WIDTH(8), .POLY(8'h07), .INIT(8'h00), .XOR_OUT(8'h00), .REFLECT_OUT(1'b0)) u8 (
    .clk(clk), .reset(reset), .mode(mode),
    .in_valid(in_valid & ~sel16), .in_ready(ir8), .in_data(in_data), .in_last(in_last),
    .out_valid(ov8), .out_ready(out_ready), .out_data(od8), .out_last(ol8),
    .crc(crc8), .crc_valid(cv8), .crc_ok(ok8), .short_err(se8)
  );

  crc_serial_framer #(.WIDTH(16), .POLY(16'h1021), .INIT(16'hFFFF), .XOR_OUT(16'h0000), .REFLECT_OUT(1'b0)) u16 (
    .clk(clk), .reset(reset), .mode(mode),
    .in_valid(in_valid & sel16), .in_ready(ir16), .in_data(in_data), .in_last(in_last),
    .out_valid(ov16), .out_ready(out_ready), .out_data(od16), .out_last(ol16),
    .crc(crc16), .crc_valid(cv16), .crc_ok(ok16), .short_err(se16)
  );

  logic ir, ov, od, ol, cv;
  assign ir = sel16 ? ir16 : ir8;
  assign ov = sel16 ? ov16 : ov8;
  assign od = sel16 ? od16 : od8;
  assign ol = sel16 ? ol16 : ol8;
  assign cv = sel16 ? cv16 : cv8;

  int           checks = 0;
  int           fails  = 0;
  logic [255:0] obits;
  int           out_n;
  int           first_last;

  // Drives one frame MSB-first and records every output transfer into obits.
  task automatic send_frame(input logic [255:0] bits, input int n, input logic m, input bit stall);
    int i;
    int cyc;
    bit done;
    bit xin;
    i = 0; cyc = 0; done = 0;
    obits = '0; out_n = 0; first_last = -1;
    while (!done) begin
      in_valid  = (i < n);
      in_data   = (i < n) ? bits[n-1-i] : 1'b0;
      in_last   = (i == n - 1);
      mode      = m;
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (ov && out_ready) begin
        obits = {obits[254:0], od};
        if (ol && first_last < 0) first_last = out_n;
        out_n++;
      end
      xin = in_valid && ir;
      @(posedge clk);
      #1;
      if (xin) i++;
      cyc++;
      if (i == n && cv) done = 1;
      else if (cyc > 2000) begin
        checks++; fails++;
        $display("FAIL frame_timeout: got %0d of %0d bits accepted, required completion", i, n);
        done = 1;
      end
    end
    in_valid = 0; in_last = 0; in_data = 0; out_ready = 1;
  endtask

  task automatic test_reset();
    reset = 0; sel16 = 0; mode = 0; in_valid = 0; in_data = 0; in_last = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ov8 !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", ov8); end
    checks++; if (cv8 !== 1'b0) begin fails++; $display("FAIL reset_crc_valid: got %b want 0", cv8); end
    checks++; if (crc8 !== 8'h00) begin fails++; $display("FAIL reset_crc: got %h want 00", crc8); end
    checks++; if (ok8 !== 1'b0 || se8 !== 1'b0) begin fails++; $display("FAIL reset_flags: got ok=%b short=%b want 0 0", ok8, se8); end
    reset = 1;
    @(posedge clk);
    #1;
    checks++; if (ir8 !== 1'b1) begin fails++; $display("FAIL idle_in_ready: got %b want 1", ir8); end
    $display("test_reset: crc=%h crc_valid=%b in_ready=%b", crc8, cv8, ir8);
  endtask

  task automatic test_gen_basic();
    send_frame(256'(16'hECB5), 16, 1'b0, 1'b0);
    checks++; if (obits !== 256'(24'hECB5BD)) begin fails++; $display("FAIL gen_bits: got %h want ecb5bd", obits[23:0]); end
    checks++; if (out_n !== 24) begin fails++; $display("FAIL gen_count: got %0d want 24", out_n); end
    checks++; if (first_last !== 23) begin fails++; $display("FAIL gen_out_last: got %0d want 23", first_last); end
    checks++; if (crc8 !== 8'hBD) begin fails++; $display("FAIL gen_crc: got %h want bd", crc8); end
    checks++; if (ok8 !== 1'b0 || se8 !== 1'b0) begin fails++; $display("FAIL gen_flags: got ok=%b short=%b want 0 0", ok8, se8); end
    $display("test_gen_basic: frame ecb5 -> crc=%h bits=%0d", crc8, out_n);
  endtask

  task automatic test_check();
    send_frame(256'(24'hECB5BD), 24, 1'b1, 1'b0);
    checks++; if (ok8 !== 1'b1) begin fails++; $display("FAIL check_ok: got %b want 1", ok8); end
    checks++; if (crc8 !== 8'hBD) begin fails++; $display("FAIL check_crc: got %h want bd", crc8); end
    checks++; if (se8 !== 1'b0) begin fails++; $display("FAIL check_short: got %b want 0", se8); end
    checks++; if (first_last !== 23 || out_n !== 24) begin fails++; $display("FAIL check_passthru: got last=%0d n=%0d want 23 24", first_last, out_n); end
    $display("test_check: frame ecb5bd -> crc=%h ok=%b", crc8, ok8);
    send_frame(256'(24'hECB5B9), 24, 1'b1, 1'b0);
    checks++; if (ok8 !== 1'b0 || crc8 !== 8'hBD) begin fails++; $display("FAIL check_flip_crc: got ok=%b crc=%h want 0 bd", ok8, crc8); end
    $display("test_check: frame ecb5b9 -> crc=%h ok=%b", crc8, ok8);
    send_frame(256'(24'hEDB5BD), 24, 1'b1, 1'b0);
    checks++; if (ok8 !== 1'b0) begin fails++; $display("FAIL check_flip_msg: got ok=%b want 0", ok8); end
    $display("test_check: frame edb5bd -> crc=%h ok=%b", crc8, ok8);
  endtask

  task automatic test_short();
    send_frame(256'(6'b101101), 6, 1'b1, 1'b0);
    checks++; if (se8 !== 1'b1 || ok8 !== 1'b0 || crc8 !== 8'h00) begin fails++; $display("FAIL short_6: got short=%b ok=%b crc=%h want 1 0 00", se8, ok8, crc8); end
    $display("test_short: 6-bit frame -> short=%b ok=%b", se8, ok8);
    send_frame(256'(1'b1), 1, 1'b1, 1'b0);
    checks++; if (se8 !== 1'b1 || cv8 !== 1'b1 || ok8 !== 1'b0) begin fails++; $display("FAIL short_1: got short=%b valid=%b ok=%b want 1 1 0", se8, cv8, ok8); end
    $display("test_short: 1-bit frame -> short=%b", se8);
    send_frame(256'(8'h00), 8, 1'b1, 1'b0);
    checks++; if (se8 !== 1'b1 || ok8 !== 1'b0) begin fails++; $display("FAIL short_8: got short=%b ok=%b want 1 0", se8, ok8); end
    $display("test_short: 8-bit frame -> short=%b ok=%b", se8, ok8);
    send_frame(256'(9'b1_0000_0111), 9, 1'b1, 1'b0);
    checks++; if (se8 !== 1'b0 || ok8 !== 1'b1 || crc8 !== 8'h07) begin fails++; $display("FAIL min_9: got short=%b ok=%b crc=%h want 0 1 07", se8, ok8, crc8); end
    $display("test_short: 9-bit frame -> short=%b ok=%b crc=%h", se8, ok8, crc8);
  endtask

  task automatic test_crc16();
    logic [255:0] ref_bits;
    sel16 = 1;
    send_frame(256'(72'h313233343536373839), 72, 1'b0, 1'b0);
    checks++; if (crc16 !== 16'h29B1) begin fails++; $display("FAIL crc16: got %h want 29b1", crc16); end
    checks++; if (obits !== 256'({72'h313233343536373839, 16'h29B1}) || out_n !== 88) begin fails++; $display("FAIL crc16_bits: got n=%0d tail=%h want 88 29b1", out_n, obits[15:0]); end
    ref_bits = obits;
    $display("test_crc16: \"123456789\" -> crc=%h bits=%0d", crc16, out_n);
    send_frame(256'(72'h313233343536373839), 72, 1'b0, 1'b1);
    checks++; if (obits !== ref_bits || out_n !== 88) begin fails++; $display("FAIL crc16_stall_bits: got n=%0d tail=%h want 88 29b1", out_n, obits[15:0]); end
    checks++; if (crc16 !== 16'h29B1) begin fails++; $display("FAIL crc16_stall: got %h want 29b1", crc16); end
    $display("test_crc16: stalled -> crc=%h bits=%0d", crc16, out_n);
    sel16 = 0;
  endtask

  task automatic test_reset_mid_append();
    logic [15:0] msg;
    msg = 16'hECB5;
    mode = 0; out_ready = 1;
    for (int i = 0; i < 18; i++) begin
      in_valid = (i < 16);
      in_data  = (i < 16) ? msg[15-i] : 1'b0;
      in_last  = (i == 15);
      @(posedge clk);
      #1;
    end
    in_valid = 0; in_last = 0;
    checks++; if (ov8 !== 1'b1) begin fails++; $display("FAIL append_active: got out_valid=%b want 1", ov8); end
    reset = 0;
    @(posedge clk);
    #1;
    checks++; if (ov8 !== 1'b0 || cv8 !== 1'b0 || crc8 !== 8'h00) begin fails++; $display("FAIL mid_reset: got out_valid=%b crc_valid=%b crc=%h want 0 0 00", ov8, cv8, crc8); end
    reset = 1;
    @(posedge clk);
    #1;
    send_frame(256'(16'hECB5), 16, 1'b0, 1'b0);
    checks++; if (crc8 !== 8'hBD || obits !== 256'(24'hECB5BD)) begin fails++; $display("FAIL post_reset: got crc=%h bits=%h want bd ecb5bd", crc8, obits[23:0]); end
    $display("test_reset_mid_append: post-reset crc=%h", crc8);
  endtask

  task automatic test_back_to_back();
    logic [31:0] bits;
    int i, cyc, gap1, gap2;
    bit xin, got1, seen17;
    logic [7:0] crc_first;
    logic cv_after;
    bits = 32'hECB5_0000;
    i = 0; cyc = 0; gap1 = 0; gap2 = 0; got1 = 0; seen17 = 0;
    crc_first = 8'hXX; cv_after = 1'bx;
    obits = '0; out_n = 0;
    mode = 0; out_ready = 1;
    while (!(i == 32 && cv8) && cyc < 200) begin
      in_valid = (i < 32);
      in_data  = (i < 32) ? bits[31-i] : 1'b0;
      in_last  = (i == 15) || (i == 31);
      @(negedge clk);
      if (ov8) begin obits = {obits[254:0], od8}; out_n++; end
      if (!ir8 && i == 16) gap1++;
      if (!ir8 && i == 32) gap2++;
      if (i == 16 && cv8 && !got1) begin crc_first = crc8; got1 = 1; end
      if (i == 17 && !seen17) begin cv_after = cv8; seen17 = 1; end
      xin = in_valid && ir8;
      @(posedge clk);
      #1;
      if (xin) i++;
      cyc++;
    end
    in_valid = 0; in_last = 0;
    checks++; if (crc_first !== 8'hBD) begin fails++; $display("FAIL b2b_crc1: got %h want bd", crc_first); end
    checks++; if (crc8 !== 8'h00 || cv8 !== 1'b1) begin fails++; $display("FAIL b2b_crc2: got crc=%h valid=%b want 00 1", crc8, cv8); end
    checks++; if (gap1 !== 8 || gap2 !== 8) begin fails++; $display("FAIL b2b_gap: got %0d %0d want 8 8", gap1, gap2); end
    checks++; if (cyc !== 48) begin fails++; $display("FAIL b2b_cycles: got %0d want 48", cyc); end
    checks++; if (cv_after !== 1'b0) begin fails++; $display("FAIL b2b_valid_clear: got %b want 0", cv_after); end
    checks++; if (obits !== 256'(48'hECB5BD_000000)) begin fails++; $display("FAIL b2b_bits: got %h want ecb5bd000000", obits[47:0]); end
    $display("test_back_to_back: crc1=%h crc2=%h gaps=%0d/%0d cycles=%0d", crc_first, crc8, gap1, gap2, cyc);
  endtask

  initial begin
    test_reset();
    test_gen_basic();
    test_check();
    test_short();
    test_crc16();
    test_reset_mid_append();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
